gf251_mul_32_arb: RTL and testbench

//  Round-robin arbiter/scheduler that shares one pipelined gf251_mul_32 (4 lanes x 8-bit GF(251) multiply) among N requesters.

---
 rtl/gf251_pkg.sv | 32 +++
 rtl/gf251_mul_32.sv | 26 ++
 rtl/gf251_mul_32_arb.sv | 121 ++++++++++++
 tb/tb_gf251_mul_32_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf251_pkg.sv
// Shared GF(251) definitions: field constants, lane layout, result-tag type and helpers.
// Used by the shared lane multiplier and by the arbiter that schedules work onto it.
package gf251_pkg;

  localparam int GF_Q     = 251;
  localparam int LANES    = 4;
  localparam int LANE_W   = 8;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // 2^8 == 5 (mod 251): fold the high byte twice, then one conditional subtract.
  function automatic logic [LANE_W-1:0] gf_reduce(input logic [2*LANE_W-1:0] p);
    logic [10:0] t1;
    logic [8:0]  t2;
    t1 = 11'(p[15:8]) * 11'd5 + 11'(p[7:0]);
    t2 = 9'(t1[10:8]) * 9'd5 + 9'(t1[7:0]);
    if (t2 >= 9'(GF_Q)) t2 = t2 - 9'(GF_Q);
    return t2[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/gf251_mul_32.sv
// Four-lane 8-bit GF(251) multiplier, two register stages: raw product, then reduction.
// No reset on purpose: o_done follows i_start two cycles later regardless of reset.
module gf251_mul_32
  import gf251_pkg::*;
(
  input  logic        i_clk,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic        i_start,
  output logic [31:0] o_o,
  output logic        o_done
);

  logic [2*LANE_W-1:0] prod [LANES];
  logic                prod_v;

  always_ff @(posedge i_clk) begin
    prod_v <= i_start;
    o_done <= prod_v;
    for (int l = 0; l < LANES; l++) begin
      prod[l]                  <= i_x[l*LANE_W +: LANE_W] * i_y[l*LANE_W +: LANE_W];
      o_o[l*LANE_W +: LANE_W]  <= gf_reduce(prod[l]);
    end
  end

endmodule

// File: rtl/gf251_mul_32_arb.sv
// Round-robin scheduler sharing one gf251_mul_32 among N_REQ requesters; one issue per cycle,
// results tagged with requester id, grant->result latency MUL_LAT+2, no result backpressure.
module gf251_mul_32_arb
  import gf251_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_en_mask,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [32*N_REQ-1:0]   i_x,
  input  logic [32*N_REQ-1:0]   i_y,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [31:0]           o_res,
  output logic                  o_res_valid,
  output logic [ID_W-1:0]       o_res_id,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int FL_W = clog2(MUL_LAT + 2);

  logic [N_REQ-1:0] elig;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pick;
  logic             found;
  logic [FL_W-1:0]  flush_cnt;
  logic             flushing;

  logic             iss_v;
  logic [ID_W-1:0]  iss_id;
  logic [31:0]      iss_x;
  logic [31:0]      iss_y;
  tag_t             tag_pipe [MUL_LAT];

  logic [31:0]      mul_o;
  logic             mul_done;

  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] el, input logic [ID_W-1:0] p);
    logic            hit;
    logic [ID_W-1:0] idx;
    int              k;
    hit = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(p) + i) % N_REQ;
      if (!hit && el[k]) begin
        hit = 1'b1;
        idx = ID_W'(k);
      end
    end
    return {hit, idx};
  endfunction

  assign flushing = (flush_cnt != '0);

  always_comb begin
    elig          = i_req & i_en_mask & {N_REQ{~i_rst}} & {N_REQ{~flushing}};
    {found, pick} = rr_pick(elig, ptr);
    o_gnt         = '0;
    if (found) o_gnt[pick] = 1'b1;
  end

  always_comb begin
    o_busy = iss_v | o_res_valid;
    for (int i = 0; i < MUL_LAT; i++) o_busy = o_busy | tag_pipe[i].valid;
  end

  gf251_mul_32 u_mul (
    .i_clk   (i_clk),
    .i_x     (iss_x),
    .i_y     (iss_y),
    .i_start (iss_v),
    .o_o     (mul_o),
    .o_done  (mul_done)
  );

  // The multiplier keeps running through reset, so its tail is masked by the flush window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr         <= ID_W'(N_REQ - 1);
      flush_cnt   <= FL_W'(MUL_LAT + 1);
      iss_v       <= 1'b0;
      iss_id      <= '0;
      iss_x       <= '0;
      iss_y       <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
      o_res       <= '0;
      o_res_valid <= 1'b0;
      o_res_id    <= '0;
      o_err       <= 1'b0;
    end else begin
      if (found) ptr <= pick;
      if (flushing) flush_cnt <= flush_cnt - FL_W'(1);

      iss_v <= found;
      if (found) begin
        iss_id <= pick;
        iss_x  <= i_x[32*pick +: 32];
        iss_y  <= i_y[32*pick +: 32];
      end

      tag_pipe[0].valid <= iss_v;
      tag_pipe[0].id    <= MAX_ID_W'(iss_id);
      for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      o_res_valid <= 1'b0;
      if (!flushing && mul_done && tag_pipe[MUL_LAT-1].valid) begin
        o_res       <= mul_o;
        o_res_id    <= tag_pipe[MUL_LAT-1].id[ID_W-1:0];
        o_res_valid <= 1'b1;
      end

      if (!flushing && (mul_done ^ tag_pipe[MUL_LAT-1].valid)) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gf251_mul_32_arb.sv
// Directed bench for gf251_mul_32_arb: scoreboard of expected {result,id,cycle} per grant,
// plus grant-order, flush-window and sticky-error checks.
module tb_gf251_mul_32_arb;

  localparam int N   = 4;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  id;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en_mask;
  logic [N-1:0]   req;
  logic [32*N-1:0] x_bus;
  logic [32*N-1:0] y_bus;
  logic [N-1:0]   gnt;
  logic [31:0]    res;
  logic           res_valid;
  logic [1:0]     res_id;
  logic           busy;
  logic           err;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   gnt_ids[$];
  int   gnt_cyc[$];

  always #5 clk = ~clk;

  gf251_mul_32_arb #(.N_REQ(N), .MUL_LAT(LAT), .ID_W(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en_mask   (en_mask),
    .i_req       (req),
    .i_x         (x_bus),
    .i_y         (y_bus),
    .o_gnt       (gnt),
    .o_res       (res),
    .o_res_valid (res_valid),
    .o_res_id    (res_id),
    .o_busy      (busy),
    .o_err       (err)
  );

  function automatic logic [31:0] gf_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'((int'(a[8*l +: 8]) * int'(b[8*l +: 8])) % 251);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (gnt != '0) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        chk("gnt_in_mask_req", 32'(gnt & ~(en_mask & req)), 32'd0);
        for (int k = 0; k < N; k++) begin
          if (gnt[k]) begin
            sb.push_back('{res: gf_model(x_bus[32*k +: 32], y_bus[32*k +: 32]),
                           id: 2'(k), cyc: cyc + LAT + 2});
            gnt_ids.push_back(k);
            gnt_cyc.push_back(cyc);
          end
        end
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_value", res, e.res);
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_grants(input int n, input string tag);
    int b;
    b = 0;
    while (gnt_ids.size() < n && b < 100) begin
      @(posedge clk);
      b++;
    end
    chk(tag, 32'(gnt_ids.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int b;
    b = 0;
    while ((sb.size() != 0 || busy) && b < 100) begin
      @(posedge clk);
      b++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic clear_logs();
    gnt_ids.delete();
    gnt_cyc.delete();
  endtask

  task automatic set_all(input logic [31:0] xv, input logic [31:0] yv);
    for (int k = 0; k < N; k++) begin
      x_bus[32*k +: 32] = xv;
      y_bus[32*k +: 32] = yv;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_mask = 4'b1111; req = 4'b1111; x_bus = '0; y_bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; req = '0;
    clear_logs();

    // Single requester, latency checked by the scoreboard.
    set_all(32'h22222222, 32'h44444444);
    req = 4'b0001;
    wait_grants(1, "t1_grant");
    #1 req = '0;
    wait_drain("t1_drain");
    chk("t1_res", res, 32'h35353535);
    chk("t1_id", 32'(res_id), 32'd0);

    // All requesting: strict rotation from a fresh pointer.
    pulse_reset();
    set_all(32'h12121212, 32'h87878787);
    req = 4'b1111;
    wait_grants(8, "t2_grants");
    #1 req = '0;
    for (int i = 0; i < 8; i++) chk("t2_order", 32'(gnt_ids[i]), 32'(i % 4));
    for (int i = 1; i < 8; i++) chk("t2_b2b", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd1);
    wait_drain("t2_drain");
    chk("t2_res", res, 32'hABABABAB);

    // Masked requesters skipped, then restored.
    clear_logs();
    for (int k = 0; k < N; k++) begin
      x_bus[32*k +: 32] = {4{8'(8'h31 + k)}};
      y_bus[32*k +: 32] = 32'hF0A50703;
    end
    en_mask = 4'b1010;
    req     = 4'b1111;
    wait_grants(6, "t3_masked");
    #1 en_mask = 4'b1111;
    wait_grants(9, "t3_restored");
    #1 req = '0;
    for (int i = 0; i < 6; i++) chk("t3_alt", 32'(gnt_ids[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    chk("t3_after0", 32'(gnt_ids[6]), 32'd0);
    chk("t3_after1", 32'(gnt_ids[7]), 32'd1);
    chk("t3_after2", 32'(gnt_ids[8]), 32'd2);
    wait_drain("t3_drain");

    // Mixed lanes, single requester at full rate.
    clear_logs();
    set_all(32'h02000102, 32'h80FA0103);
    req = 4'b0001;
    wait_grants(4, "t4_grants");
    #1 req = '0;
    for (int i = 1; i < 4; i++) chk("t4_full_rate", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd1);
    wait_drain("t4_drain");
    chk("t4_res", res, 32'h05000106);
    @(negedge clk);
    chk("t4_hold_valid", 32'(res_valid), 32'd0);
    chk("t4_hold_res", res, 32'h05000106);

    // Reset with ops in flight: results discarded, grants blocked for the flush window.
    @(posedge clk);
    #1 clear_logs();
    set_all(32'h22222222, 32'h44444444);
    req = 4'b1111;
    wait_grants(3, "t5_grants");
    #1 rst = 1'b1;
    sb.delete();
    req = 4'b0001;
    @(negedge clk);
    chk("t5_gnt_in_rst", 32'(gnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("t5_flush_gnt", 32'(gnt), 32'd0);
      chk("t5_flush_err", 32'(err), 32'd0);
    end
    @(negedge clk);
    chk("t5_first_gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1 req = '0;
    wait_drain("t5_drain");
    chk("t5_res", res, 32'h35353535);
    chk("t5_err", 32'(err), 32'd0);

    // Spurious multiplier completion with an empty tag pipe.
    @(negedge clk);
    chk("t6_err_before", 32'(err), 32'd0);
    force dut.mul_done = 1'b1;
    @(negedge clk);
    release dut.mul_done;
    chk("t6_err_set", 32'(err), 32'd1);
    chk("t6_no_result", 32'(res_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 32'(err), 32'd1);
    pulse_reset();
    @(negedge clk);
    chk("t6_err_cleared", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
